// File: rtl/loop_ctrl_pkg.sv
// Shared state encoding and elaboration helpers for the multitrack loop controller.
package loop_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REC  = 2'd1,
      ST_PLAY = 2'd2
   } trackState_t;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned w;
      w = 0;
      while ((64'd1 << w) < 64'(n)) w = w + 1;
      return w;
   endfunction

endpackage

// File: rtl/track_channel_fsm.sv
// One track: IDLE/REC/PLAY mode, captured take length, wrap-around play pointer.
module track_channel_fsm
   import loop_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W = 10
)(
   input  logic              clk,
   input  logic              resetn,
   input  logic              tick,
   input  logic              recReq,
   input  logic              playReq,
   input  logic              recGrant,
   input  logic [ADDR_W:0]   recCount,
   output logic              canRec_c,
   output logic              recBusy,
   output logic              playEn,
   output logic [ADDR_W-1:0] playAddr,
   output logic              trackValid
);

   localparam int unsigned CW    = ADDR_W + 1;
   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam logic [CW-1:0] LEN_FULL = CW'(DEPTH);

   trackState_t   state;
   logic [CW-1:0] len;
   logic [CW-1:0] ptrInc;
   logic          rearm;

   assign ptrInc   = {1'b0, playAddr} + CW'(1);
   assign canRec_c = (state == ST_IDLE) && !rearm;
   assign recBusy  = (state == ST_REC);
   assign playEn   = (state == ST_PLAY);

   // recCount already includes a write landing on this clk's tick
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= ST_IDLE;
         playAddr   <= '0;
         len        <= '0;
         trackValid <= 1'b0;
         rearm      <= 1'b0;
      end else begin
         if (!recReq) rearm <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (recGrant) begin
                  state      <= ST_REC;
                  trackValid <= 1'b0;
                  len        <= '0;
               end else if (playReq && trackValid) begin
                  state    <= ST_PLAY;
                  playAddr <= '0;
               end
            end
            ST_REC: begin
               if (!recReq) begin
                  state      <= ST_IDLE;
                  len        <= recCount;
                  trackValid <= (recCount != '0);
               end else if (tick && (recCount == LEN_FULL)) begin
                  state      <= ST_IDLE;
                  len        <= LEN_FULL;
                  trackValid <= 1'b1;
                  rearm      <= 1'b1;
               end
            end
            ST_PLAY: begin
               if (!playReq) begin
                  state    <= ST_IDLE;
                  playAddr <= '0;
               end else if (tick) begin
                  playAddr <= (ptrInc == len) ? '0 : ptrInc[ADDR_W-1:0];
               end
            end
            default: begin
               state    <= ST_IDLE;
               playAddr <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/multitrack_loop_ctrl.sv
// Record/playback controller for NUM_TRACKS loop tracks sharing one RAM write port.
module multitrack_loop_ctrl
   import loop_ctrl_pkg::*;
#(
   parameter  int unsigned NUM_TRACKS = 2,
   parameter  int unsigned ADDR_W     = 10,
   localparam int unsigned TRK_W      = (NUM_TRACKS > 1) ? clog2(NUM_TRACKS) : 1
)(
   input  logic                         clk,
   input  logic                         resetn,
   input  logic                         tick,
   input  logic [NUM_TRACKS-1:0]        rec_sw,
   input  logic [NUM_TRACKS-1:0]        play_sw,
   output logic                         rec_we,
   output logic [TRK_W-1:0]             rec_track,
   output logic [ADDR_W-1:0]            rec_addr,
   output logic [NUM_TRACKS-1:0]        rec_busy,
   output logic [NUM_TRACKS-1:0]        play_en,
   output logic [NUM_TRACKS*ADDR_W-1:0] play_addr,
   output logic [NUM_TRACKS-1:0]        track_valid
);

   localparam int unsigned CW = ADDR_W + 1;

   logic [NUM_TRACKS-1:0] recMeta, recSync, playMeta, playSync;
   logic [NUM_TRACKS-1:0] canRec, recGrant;
   logic [CW-1:0]         wptr, recCount;
   logic                  anyBusy;
   logic                  found;

   // Two-flop synchronisers for the board switches
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         recMeta  <= '0;
         recSync  <= '0;
         playMeta <= '0;
         playSync <= '0;
      end else begin
         recMeta  <= rec_sw;
         recSync  <= recMeta;
         playMeta <= play_sw;
         playSync <= playMeta;
      end
   end

   assign anyBusy  = |rec_busy;
   assign recCount = wptr + CW'(tick);
   assign rec_we   = anyBusy && tick;
   assign rec_addr = wptr[ADDR_W-1:0];

   // Lowest eligible requester wins, only while the write port is free
   always_comb begin
      recGrant = '0;
      found    = 1'b0;
      for (int i = 0; i < int'(NUM_TRACKS); i++) begin
         if (!found && !anyBusy && recSync[i] && canRec[i]) begin
            recGrant[i] = 1'b1;
            found       = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)               wptr <= '0;
      else if (|recGrant)        wptr <= '0;
      else if (anyBusy && tick)  wptr <= recCount;
   end

   always_comb begin
      rec_track = '0;
      for (int i = 0; i < int'(NUM_TRACKS); i++) begin
         if (rec_busy[i]) rec_track = TRK_W'(i);
      end
   end

   for (genvar g = 0; g < NUM_TRACKS; g++) begin : gTrack
      track_channel_fsm #(.ADDR_W(ADDR_W)) uChan (
         .clk        (clk),
         .resetn     (resetn),
         .tick       (tick),
         .recReq     (recSync[g]),
         .playReq    (playSync[g]),
         .recGrant   (recGrant[g]),
         .recCount   (recCount),
         .canRec_c   (canRec[g]),
         .recBusy    (rec_busy[g]),
         .playEn     (play_en[g]),
         .playAddr   (play_addr[g*ADDR_W +: ADDR_W]),
         .trackValid (track_valid[g])
      );
   end

endmodule
